// File: rtl/rename_resolver_pkg.sv
// Shared definitions for the rename resolve stage.
// - AREG_BITS / PREG_BITS : field widths of the registered lane record.
// - PREG_NONE             : physical register 0, meaning "none/invalid".
// - rename_lane_t         : one lane of the registered output bundle.
package rename_resolver_pkg;

  localparam int AREG_BITS = 5;
  localparam int PREG_BITS = 6;

  localparam logic [PREG_BITS-1:0] PREG_NONE = '0;

  // Output-register record. Its widths follow the package constants, so the
  // AREG_W/PREG_W parameters of the stage must stay at these values.
  typedef struct packed {
    logic                 lane_valid;
    logic [AREG_BITS-1:0] rd;
    logic [PREG_BITS-1:0] prs1;
    logic [PREG_BITS-1:0] prs2;
    logic [PREG_BITS-1:0] prn;
    logic                 tag;
  } rename_lane_t;

endpackage

// File: rtl/rename_resolver_if.sv
// Bundle interface between decode/rename-table query, the resolve stage and
// the issuer.
// - slave  : the resolve stage (consumes i_*, drives o_*).
// - master : the environment driving the stage.
// Signals: input bundle (i_valid/o_ready, per-lane fields and table lookups),
// allocation pops (o_alloc), output bundle (o_valid/i_ready, resolved lanes),
// control (i_halt, i_tag_clear, i_flush) and the sticky o_panic.
interface rename_resolver_if
  import rename_resolver_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int AREG_W = AREG_BITS,
  parameter int PREG_W = PREG_BITS
);

  logic                           i_valid;
  logic                           o_ready;
  logic [WIDTH-1:0]               i_lane_valid;
  logic [WIDTH-1:0][AREG_W-1:0]   i_rd;
  logic [WIDTH-1:0][AREG_W-1:0]   i_rs1;
  logic [WIDTH-1:0][AREG_W-1:0]   i_rs2;
  logic [WIDTH-1:0]               i_writes;
  logic [WIDTH-1:0]               i_jumps;
  logic [WIDTH-1:0][PREG_W-1:0]   i_q_rs1;
  logic [WIDTH-1:0][PREG_W-1:0]   i_q_rs2;
  logic [WIDTH-1:0][PREG_W-1:0]   i_q_rn;
  logic [WIDTH-1:0]               o_alloc;
  logic                           o_valid;
  logic                           i_ready;
  logic [WIDTH-1:0]               o_lane_valid;
  logic [WIDTH-1:0][AREG_W-1:0]   o_rd;
  logic [WIDTH-1:0][PREG_W-1:0]   o_prs1;
  logic [WIDTH-1:0][PREG_W-1:0]   o_prs2;
  logic [WIDTH-1:0][PREG_W-1:0]   o_prn;
  logic [WIDTH-1:0]               o_tag;
  logic                           i_halt;
  logic                           i_tag_clear;
  logic                           i_flush;
  logic                           o_panic;

  modport slave (
    input  i_valid, i_lane_valid, i_rd, i_rs1, i_rs2, i_writes, i_jumps,
           i_q_rs1, i_q_rs2, i_q_rn, i_ready, i_halt, i_tag_clear, i_flush,
    output o_ready, o_alloc, o_valid, o_lane_valid, o_rd, o_prs1, o_prs2,
           o_prn, o_tag, o_panic
  );

  modport master (
    output i_valid, i_lane_valid, i_rd, i_rs1, i_rs2, i_writes, i_jumps,
           i_q_rs1, i_q_rs2, i_q_rn, i_ready, i_halt, i_tag_clear, i_flush,
    input  o_ready, o_alloc, o_valid, o_lane_valid, o_rd, o_prs1, o_prs2,
           o_prn, o_tag, o_panic
  );

endinterface

// File: rtl/rename_resolver_bypass.sv
// rename_bypass: combinational intra-bundle source resolution.
// - writes       : per-lane "lane writes a destination" (valid, flagged, rd!=0).
// - rd, rs1, rs2 : architectural registers per lane.
// - q_rs1, q_rs2 : rename-table lookups per lane.
// - q_rn         : destination physical register allocated to each lane.
// - prs1, prs2   : resolved physical sources per lane.
// A source takes the destination of the youngest older lane in the bundle
// that writes the same architectural register; otherwise the table lookup.
// Source register 0 always resolves to physical 0.
module rename_bypass
  import rename_resolver_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int AREG_W = AREG_BITS,
  parameter int PREG_W = PREG_BITS
) (
  input  logic [WIDTH-1:0]             writes,
  input  logic [WIDTH-1:0][AREG_W-1:0] rd,
  input  logic [WIDTH-1:0][AREG_W-1:0] rs1,
  input  logic [WIDTH-1:0][AREG_W-1:0] rs2,
  input  logic [WIDTH-1:0][PREG_W-1:0] q_rs1,
  input  logic [WIDTH-1:0][PREG_W-1:0] q_rs2,
  input  logic [WIDTH-1:0][PREG_W-1:0] q_rn,
  output logic [WIDTH-1:0][PREG_W-1:0] prs1,
  output logic [WIDTH-1:0][PREG_W-1:0] prs2
);

  // NOTE: combinational logic uses blocking assignments and gives every output
  // a default before any condition, so no latch can be inferred.
  always_comb begin
    prs1 = q_rs1;
    prs2 = q_rs2;
    for (int j = 1; j < WIDTH; j++) begin
      // Ascending scan: a younger matching lane overrides an older one.
      for (int i = 0; i < j; i++) begin
        if (writes[i] && (rd[i] == rs1[j])) prs1[j] = q_rn[i];
        if (writes[i] && (rd[i] == rs2[j])) prs2[j] = q_rn[i];
      end
    end
    for (int j = 0; j < WIDTH; j++) begin
      if (rs1[j] == '0) prs1[j] = PREG_NONE;
      if (rs2[j] == '0) prs2[j] = PREG_NONE;
    end
  end

endmodule

// File: rtl/rename_resolver.sv
// rename_resolver: N-wide register-rename resolve stage.
// - i_clock, i_reset : clock and asynchronous active-low reset.
// - bus (slave)      : input bundle + table lookups, allocation pops, output
//                      bundle, speculation/flush control and panic.
// Merges table lookups with intra-bundle bypass, allocates destinations,
// tracks one level of branch speculation, registers the bundle behind a
// valid/ready handshake and raises a sticky panic on an illegal bundle or
// on an allocation stall lasting STALL_LIMIT cycles.
module rename_resolver
  import rename_resolver_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int AREG_W      = AREG_BITS,
  parameter int PREG_W      = PREG_BITS,
  parameter int STALL_LIMIT = 1024
) (
  input  logic             i_clock,
  input  logic             i_reset,
  rename_resolver_if.slave bus
);

  localparam int              CNT_W   = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_LIMIT);

  logic [WIDTH-1:0]             writes;
  logic [WIDTH-1:0]             jump_lane;
  logic [2:0]                   jump_cnt;
  logic                         alloc_stall, jump_stall, illegal, stall;
  logic                         ready, accept, any_jump, seen_jump;
  logic                         tag_active, panic, out_valid;
  logic [CNT_W-1:0]             stall_cnt, stall_cnt_d;
  logic [WIDTH-1:0][PREG_W-1:0] prs1, prs2;
  rename_lane_t                 lane_q [WIDTH];
  rename_lane_t                 lane_d [WIDTH];

  always_comb begin
    writes      = '0;
    jump_lane   = '0;
    jump_cnt    = '0;
    alloc_stall = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      writes[j]    = bus.i_lane_valid[j] & bus.i_writes[j] & (bus.i_rd[j] != '0);
      jump_lane[j] = bus.i_lane_valid[j] & bus.i_jumps[j];
      jump_cnt     = jump_cnt + 3'(jump_lane[j]);
      if (writes[j] && (bus.i_q_rn[j] == PREG_NONE)) alloc_stall = 1'b1;
    end
  end

  assign any_jump   = |jump_lane;
  assign jump_stall = (jump_cnt == 3'd1) && tag_active;
  // A bundle with two or more jumps is never accepted; it only raises panic.
  assign illegal    = bus.i_valid && (jump_cnt >= 3'd2);
  assign stall      = alloc_stall | jump_stall | illegal | bus.i_halt |
                      bus.i_flush | panic;
  // Gating with reset keeps o_ready/o_alloc low while reset is held.
  assign ready      = i_reset & (~out_valid | bus.i_ready) & ~stall;
  assign accept     = bus.i_valid & ready;

  assign bus.o_ready = ready;
  assign bus.o_alloc = accept ? writes : '0;
  assign bus.o_valid = out_valid;
  assign bus.o_panic = panic;

  rename_bypass #(
    .WIDTH  (WIDTH),
    .AREG_W (AREG_W),
    .PREG_W (PREG_W)
  ) u_bypass (
    .writes (writes),
    .rd     (bus.i_rd),
    .rs1    (bus.i_rs1),
    .rs2    (bus.i_rs2),
    .q_rs1  (bus.i_q_rs1),
    .q_rs2  (bus.i_q_rs2),
    .q_rn   (bus.i_q_rn),
    .prs1   (prs1),
    .prs2   (prs2)
  );

  // Next output bundle. Jump lanes are non-speculative, lanes behind the first
  // jump are speculative, lanes ahead of it inherit the current speculation.
  always_comb begin
    seen_jump = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      lane_d[j].lane_valid = bus.i_lane_valid[j];
      lane_d[j].rd         = bus.i_rd[j];
      lane_d[j].prs1       = prs1[j];
      lane_d[j].prs2       = prs2[j];
      lane_d[j].prn        = writes[j] ? bus.i_q_rn[j] : PREG_NONE;
      if (jump_lane[j])   lane_d[j].tag = 1'b0;
      else if (seen_jump) lane_d[j].tag = 1'b1;
      else                lane_d[j].tag = tag_active;
      seen_jump = seen_jump | jump_lane[j];
    end
  end

  // Watchdog: counts consecutive cycles stuck on an exhausted free list.
  always_comb begin
    stall_cnt_d = '0;
    if (bus.i_valid && alloc_stall && !bus.i_flush)
      stall_cnt_d = (stall_cnt == CNT_MAX) ? stall_cnt : stall_cnt + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      out_valid  <= 1'b0;
      tag_active <= 1'b0;
      stall_cnt  <= '0;
      panic      <= 1'b0;
      for (int j = 0; j < WIDTH; j++) lane_q[j] <= '0;
    end else begin
      stall_cnt <= stall_cnt_d;
      if (illegal || (stall_cnt_d == CNT_MAX)) panic <= 1'b1;
      if (bus.i_flush) begin
        out_valid  <= 1'b0;
        tag_active <= 1'b0;
      end else begin
        // A new branch accepted alongside a tag clear stays speculative.
        if (accept && any_jump)   tag_active <= 1'b1;
        else if (bus.i_tag_clear) tag_active <= 1'b0;
        if (accept) begin
          out_valid <= 1'b1;
          for (int j = 0; j < WIDTH; j++) lane_q[j] <= lane_d[j];
        end else begin
          if (bus.i_ready) out_valid <= 1'b0;
          if (bus.i_tag_clear)
            for (int j = 0; j < WIDTH; j++) lane_q[j].tag <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.o_lane_valid = '0;
    bus.o_rd         = '0;
    bus.o_prs1       = '0;
    bus.o_prs2       = '0;
    bus.o_prn        = '0;
    bus.o_tag        = '0;
    for (int j = 0; j < WIDTH; j++) begin
      bus.o_lane_valid[j] = lane_q[j].lane_valid;
      bus.o_rd[j]         = lane_q[j].rd;
      bus.o_prs1[j]       = lane_q[j].prs1;
      bus.o_prs2[j]       = lane_q[j].prs2;
      bus.o_prn[j]        = lane_q[j].prn;
      bus.o_tag[j]        = lane_q[j].tag;
    end
  end

endmodule
